// File: rtl/ieee2nfloat_stage_if.sv
// Valid/ready bus for the IEEE-754 to FloPoCo-native converter.
// The master drives operands and output backpressure; the slave is the stage.
interface ieee2nfloat_stage_if #(
  parameter int DATA_TYPE = 32
);
  logic [DATA_TYPE-1:0] ins;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [DATA_TYPE+1:0] outs;
  logic                 outs_valid;
  logic                 outs_ready;

  modport master (output ins, ins_valid, outs_ready,
                  input  ins_ready, outs, outs_valid);
  modport slave  (input  ins, ins_valid, outs_ready,
                  output ins_ready, outs, outs_valid);
endinterface

// File: rtl/ieee2nfloat_stage.sv
// Elastic IEEE-754 single -> FloPoCo exception-tagged float stage with a 2-slot skid buffer.
// Optional subnormal flush counter enabled by defining IEEE2NFLOAT_FLUSH_CNT_EN.
module ieee2nfloat_stage #(
  parameter int DATA_TYPE = 32,
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef IEEE2NFLOAT_FLUSH_CNT_EN
  output logic [15:0]          flush_count,
`endif
  ieee2nfloat_stage_if.slave   bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t               state, nxt;
  logic [DATA_TYPE+1:0] m_data, s_data, conv;
  logic                 ins_ready_q;
  logic                 accept, drain;
  logic                 ld_m_in, ld_m_s, ld_s;

  logic [EXP_W-1:0]     e;
  logic [FRAC_W-1:0]    f;
  logic                 sgn;

  assign sgn = bus.ins[DATA_TYPE-1];
  assign e   = bus.ins[FRAC_W +: EXP_W];
  assign f   = bus.ins[FRAC_W-1:0];

  // Subnormals flush to a signed zero; only inf/NaN are distinguished by fraction.
  always_comb begin
    conv = {2'b01, bus.ins};
    if (e == '0)
      conv = {2'b00, sgn, {(DATA_TYPE-1){1'b0}}};
    else if (&e)
      conv = {(f == '0) ? 2'b10 : 2'b11, bus.ins};
  end

  assign accept = bus.ins_valid & ins_ready_q;
  assign drain  = (state != EMPTY) & bus.outs_ready;

  always_comb begin
    nxt     = state;
    ld_m_in = 1'b0;
    ld_m_s  = 1'b0;
    ld_s    = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        nxt     = ONE;
        ld_m_in = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          ld_m_in = 1'b1;
        end else if (accept) begin
          nxt  = TWO;
          ld_s = 1'b1;
        end else if (drain) begin
          nxt = EMPTY;
        end
      end
      TWO: if (drain) begin
        nxt    = ONE;
        ld_m_s = 1'b1;
      end
      default: nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= nxt;
  end

  // ins_ready is precomputed from next state so it never depends on outs_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data      <= '0;
      s_data      <= '0;
      ins_ready_q <= 1'b1;
    end else begin
      if (ld_m_in)     m_data <= conv;
      else if (ld_m_s) m_data <= s_data;
      if (ld_s)        s_data <= conv;
      ins_ready_q <= (nxt != TWO);
    end
  end

  assign bus.outs       = m_data;
  assign bus.outs_valid = (state != EMPTY);
  assign bus.ins_ready  = ins_ready_q;

`ifdef IEEE2NFLOAT_FLUSH_CNT_EN
  logic subn;
  assign subn = (e == '0) && (f != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flush_count <= '0;
    else if (accept && subn && (flush_count != 16'hFFFF))
      flush_count <= flush_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ieee2nfloat_stage.sv
// Scoreboard bench for ieee2nfloat_stage: driver pushes expected words, monitor pops on each transfer.
module tb_ieee2nfloat_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ieee2nfloat_stage_if #(.DATA_TYPE(32)) bus ();

`ifdef IEEE2NFLOAT_FLUSH_CNT_EN
  logic [15:0] flush_count;
  ieee2nfloat_stage dut (.clk(clk), .rst(rst), .flush_count(flush_count), .bus(bus));
`else
  ieee2nfloat_stage dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_stall  = 0;
  logic [33:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, req);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] f;
    e = w[30:23];
    f = w[22:0];
    if (e == 8'h00) return {2'b00, w[31], 31'b0};
    if (e == 8'hFF) return {(f == 23'b0) ? 2'b10 : 2'b11, w};
    return {2'b01, w};
  endfunction

  // Monitor: every completed transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && bus.outs_valid && bus.outs_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard: unexpected word 0x%09h", bus.outs);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if (bus.outs !== e) begin
          n_errors++;
          $display("FAIL scoreboard: got 0x%09h expected 0x%09h", bus.outs, e);
        end
      end
    end
  end

  // Offer one word; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [33:0] expv);
    bit ok;
    bus.ins       = w;
    bus.ins_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ins_ready) begin ok = 1'b1; break; end
      n_stall++;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: ins_ready 0 expected 1");
      bus.ins_valid = 1'b0;
      return;
    end
    exp_q.push_back(expv);
    @(posedge clk);
    #1 bus.ins_valid = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    logic [31:0] w;
    bus.ins        = '0;
    bus.ins_valid  = 1'b0;
    bus.outs_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_outs_valid", {33'b0, bus.outs_valid}, 34'd0);
    chk("rst_ins_ready",  {33'b0, bus.ins_ready},  34'd1);
    chk("rst_outs",       bus.outs,                34'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // Normal 1.0, single-cycle pulse
    bus.outs_ready = 1'b1;
    send(32'h3F800000, 34'h13F800000);
    chk("norm_valid", {33'b0, bus.outs_valid}, 34'd1);
    chk("norm_outs",  bus.outs,                34'h13F800000);
    @(posedge clk); #1;
    chk("norm_pulse", {33'b0, bus.outs_valid}, 34'd0);

    // Specials back-to-back
    t0 = cyc;
    send(32'h80000000, 34'h080000000);
    send(32'h7F800000, 34'h27F800000);
    send(32'h7FC00000, 34'h37FC00000);
    send(32'h00000001, 34'h000000000);
    chk("spec_throughput", 34'(cyc - t0), 34'd4);
    drain_wait();

    // Backpressure
    bus.outs_ready = 1'b0;
    send(32'h40000000, 34'h140000000);
    send(32'h40400000, 34'h140400000);
    chk("bp_ready_low", {33'b0, bus.ins_ready}, 34'd0);
    chk("bp_outs",      bus.outs,               34'h140000000);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold",      bus.outs,               34'h140000000);
    chk("bp_hold_vld",  {33'b0, bus.outs_valid}, 34'd1);
    bus.outs_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second",    bus.outs,               34'h140400000);
    chk("bp_ready_back", {33'b0, bus.ins_ready}, 34'd1);
    drain_wait();

    // 100 random words streamed with simultaneous accept/drain
    n_stall = 0;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      if (i % 10 == 0) w[30:23] = 8'h00;
      if (i % 10 == 1) w[30:23] = 8'hFF;
      if (i % 10 == 2) w[30:0]  = 31'h7F800000;
      send(w, model(w));
    end
    chk("rand_no_stall", 34'(n_stall), 34'd0);
    drain_wait();

    // Reset with two words buffered
    bus.outs_ready = 1'b0;
    send(32'h41000000, 34'h141000000);
    send(32'h41100000, 34'h141100000);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_valid", {33'b0, bus.outs_valid}, 34'd0);
    chk("mid_rst_ready", {33'b0, bus.ins_ready},  34'd1);
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    bus.outs_ready = 1'b1;
    send(32'hBF800000, 34'h1BF800000);
    chk("post_rst_outs", bus.outs, 34'h1BF800000);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_empty", {33'b0, bus.outs_valid}, 34'd0);

`ifdef IEEE2NFLOAT_FLUSH_CNT_EN
    @(posedge clk); #2 rst = 1'b0;
    exp_q.delete();
    #1 chk("fc_reset", {18'b0, flush_count}, 34'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    send(32'h00000001, 34'h000000000);
    send(32'h807FFFFF, 34'h080000000);
    send(32'h00400000, 34'h000000000);
    send(32'h00000000, 34'h000000000);
    chk("fc_three", {18'b0, flush_count}, 34'd3);
    for (int i = 0; i < 65536; i++) send(32'h00000001, 34'h000000000);
    chk("fc_saturate", {18'b0, flush_count}, 34'h0FFFF);
    drain_wait();
`endif

    drain_wait();
    chk("sb_empty", 34'(exp_q.size()), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ieee2nfloat_stage.md
Name: ieee2nfloat_stage

Overview:
- Registered, elastic IEEE-754 single-precision to FloPoCo-native float converter.
- Sits directly upstream of the FloPoCo divider core, on each operand path of the floating-point divide unit.
- Converts a 32-bit IEEE word to the 34-bit exception-tagged format on a valid/ready handshake.
- Includes a 2-slot skid buffer so ins_ready is fully registered and throughput is one word per cycle.

Parameters:
- DATA_TYPE, 32, IEEE word width; must equal 1+EXP_W+FRAC_W.
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ins  input  DATA_TYPE  IEEE-754 operand.
- ins_valid  input  1  operand valid.
- ins_ready  output  1  stage can accept; driven from a register.
- outs  output  DATA_TYPE+2  converted word: [DATA_TYPE+1:DATA_TYPE]=exc, then sign, exponent, fraction.
- outs_valid  output  1  converted word valid.
- outs_ready  input  1  downstream accepts.

Behaviour:
- Conversion, combinational on ins, captured at acceptance. Let e=ins exponent, f=ins fraction:
  - e==0 (zero or subnormal): exc=00. Sign kept. Exponent and fraction forced to 0, so subnormals flush to zero.
  - e==all-ones, f==0: exc=10 (inf). Fields passed through.
  - e==all-ones, f!=0: exc=11 (NaN). Fields passed through.
  - Otherwise: exc=01 (normal). Sign, exponent and fraction passed through unchanged.
- Storage: main register M (drives outs) and skid register S, each with a valid bit.
- States:
  - EMPTY (M and S invalid).
  - ONE (M valid, S invalid).
  - TWO (both valid).
- Handshakes: accept = ins_valid & ins_ready; drain = outs_valid & outs_ready.
- Transitions:
  - EMPTY: accept -> ONE, word into M.
  - ONE:
    - accept & drain -> ONE, new word into M.
    - accept & !drain -> TWO, new word into S.
    - drain only -> EMPTY.
  - TWO (ins_ready=0, no accept possible):
    - drain -> ONE, S moves to M.
    - no drain -> hold.
- Outputs:
  - outs_valid = M.valid.
  - ins_ready = !S.valid (registered).
  - outs driven only from M.
- Latency: 1 cycle from accept to outs_valid when EMPTY.
- Throughput: sustained 1 word/cycle with outs_ready held high.
- Ordering: strict FIFO; no word dropped or duplicated.
- Stall: outs stable while outs_valid & !outs_ready; ins ignored when ins_ready=0.
- Reset, asynchronous on rst low:
  - M.valid=0, S.valid=0, outs=0, outs_valid=0.
  - ins_ready=1 both during and after reset.
- Reset mid-operation discards all buffered words. The first accept after release behaves as from EMPTY.
- No combinational path from outs_ready to ins_ready. The ins-to-outs path is registered.

Optional Feature:
- Macro: IEEE2NFLOAT_FLUSH_CNT_EN.
- When defined:
  - Adds output port flush_count (16 bits), cleared by rst.
  - Increments by 1 on each accepted word with e==0 and f!=0 (true subnormal).
  - Saturates at 0xFFFF. Zeros are not counted.
- When undefined: no port, no counter logic. Conversion and handshake behaviour are identical in both builds.

Test Plan:
- Normal: ins=0x3F800000 (1.0), outs_ready=1 -> one cycle later outs=0x13F800000, outs_valid=1 for exactly 1 cycle.
- Specials, streamed back-to-back:
  - Inputs 0x80000000, 0x7F800000, 0x7FC00000, 0x00000001.
  - Outputs in order: 0x080000000, 0x27F800000, 0x37FC00000, 0x000000000.
  - Throughput 1/cycle.
- Backpressure:
  - Setup: outs_ready=0; offer 0x40000000 then 0x40400000 on consecutive cycles.
  - Expect: ins_ready falls to 0 after the second accept, and outs holds 0x140000000.
  - Then raise outs_ready: outs shows 0x140000000 then 0x140400000, and ins_ready returns to 1.
- Simultaneous accept/drain in ONE: continuous ins_valid and outs_ready for 100 random words -> outputs match the golden conversion in order, ins_ready never drops.
- Reset mid-operation:
  - Setup: TWO state (outs_ready=0, two words buffered); pulse rst low asynchronously between edges.
  - Expect immediately: outs_valid=0, ins_ready=1.
  - Next word 0xBF800000 after release appears as 0x1BF800000, with no stale words.
- IEEE2NFLOAT_FLUSH_CNT_EN build:
  - 3 subnormals (0x00000001, 0x807FFFFF, 0x00400000) plus 0x00000000 -> flush_count=3.
  - Forcing 0x10000 subnormals -> saturates at 0xFFFF.
